// File: rtl/mips_pkg.sv
// mips_pkg: opcode, ALU_OP and control-bundle definitions shared by the decode stage
package mips_pkg;
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;
  typedef struct packed {
    logic       reg_dst;
    logic       alu_src;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       reg_write;
    logic       branch;
    logic [1:0] alu_op;
  } ctrl_t;
  localparam ctrl_t CTRL_NOP = '0;
  // Bit order: reg_dst, alu_src, mem_read, mem_write, mem_to_reg, reg_write, branch
  function automatic ctrl_t decode_ctrl(input logic [5:0] op);
    return op == OP_RTYPE ? ctrl_t'({7'b1000010, ALU_FUNCT}) :
           op == OP_LW    ? ctrl_t'({7'b0110110, ALU_ADD})   :
           op == OP_SW    ? ctrl_t'({7'b0101000, ALU_ADD})   :
           op == OP_BEQ   ? ctrl_t'({7'b0000001, ALU_SUB})   :
           op == OP_ADDI  ? ctrl_t'({7'b0100010, ALU_ADD})   : CTRL_NOP;
  endfunction
  function automatic logic is_legal(input logic [5:0] op);
    return op == OP_RTYPE || op == OP_LW || op == OP_SW || op == OP_BEQ || op == OP_ADDI;
  endfunction
  function automatic logic uses_rt(input logic [5:0] op);
    return op == OP_RTYPE || op == OP_SW || op == OP_BEQ;
  endfunction
endpackage

// File: rtl/reg_file.sv
// reg_file: 2-read/1-write register file with write-through bypass and $0 hardwired to zero
module reg_file #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0] raddr_a_i,
  input  logic [ADDR_W-1:0] raddr_b_i,
  output logic [DATA_W-1:0] rdata_a_o,
  output logic [DATA_W-1:0] rdata_b_o
);
  logic [DATA_W-1:0] regs_q [2**ADDR_W];
  logic              wr_en;
  assign wr_en = we_i && waddr_i != '0;
  always_ff @(posedge CLK or negedge RST_N)
    if (!RST_N) for (int i = 0; i < 2**ADDR_W; i++) regs_q[i] <= '0;
    else if (wr_en) regs_q[waddr_i] <= wdata_i;
  assign rdata_a_o = raddr_a_i == '0 ? '0 : (wr_en && waddr_i == raddr_a_i) ? wdata_i : regs_q[raddr_a_i];
  assign rdata_b_o = raddr_b_i == '0 ? '0 : (wr_en && waddr_i == raddr_b_i) ? wdata_i : regs_q[raddr_b_i];
endmodule

// File: rtl/id_stage.sv
// id_stage: MIPS decode stage -- control decode, register read, load-use hazard detection
// and the ID/EX pipeline register.
module id_stage
  import mips_pkg::*;
#(
  parameter int DATA_W         = 32,
  parameter int REG_ADDR_W     = 5,
  parameter int LOAD_USE_STALL = 1
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic [DATA_W-1:0]     IF_ID_NPC,
  input  logic [31:0]           IF_ID_INST,
  input  logic                  IF_ID_VALID,
  input  logic                  FLUSH,
  input  logic                  WB_REG_WRITE,
  input  logic [REG_ADDR_W-1:0] WB_WRITE_REG,
  input  logic [DATA_W-1:0]     WB_WRITE_DATA,
  output logic                  STALL,
  output logic                  ID_EX_VALID,
  output logic [DATA_W-1:0]     ID_EX_NPC,
  output logic [DATA_W-1:0]     ID_EX_RS_DATA,
  output logic [DATA_W-1:0]     ID_EX_RT_DATA,
  output logic [DATA_W-1:0]     ID_EX_IMM,
  output logic [REG_ADDR_W-1:0] ID_EX_RS,
  output logic [REG_ADDR_W-1:0] ID_EX_RT,
  output logic [REG_ADDR_W-1:0] ID_EX_RD,
  output logic                  ID_EX_REG_DST,
  output logic                  ID_EX_ALU_SRC,
  output logic                  ID_EX_MEM_READ,
  output logic                  ID_EX_MEM_WRITE,
  output logic                  ID_EX_MEM_TO_REG,
  output logic                  ID_EX_REG_WRITE,
  output logic                  ID_EX_BRANCH,
  output logic [1:0]            ID_EX_ALU_OP,
  output logic                  ILLEGAL
);
  logic [5:0]            opcode;
  logic [REG_ADDR_W-1:0] rs, rt, rd;
  logic [DATA_W-1:0]     rs_data, rt_data, imm;
  logic                  hz, ld;
  logic                  valid_q, valid_d, ill_q, ill_d;
  ctrl_t                 ctrl_q, ctrl_d;
  logic [DATA_W-1:0]     npc_q, npc_d, rsd_q, rsd_d, rtd_q, rtd_d, imm_q, imm_d;
  logic [REG_ADDR_W-1:0] rs_q, rs_d, rt_q, rt_d, rd_q, rd_d;
  assign opcode = IF_ID_INST[31:26];
  assign rs     = IF_ID_INST[25:21];
  assign rt     = IF_ID_INST[20:16];
  assign rd     = IF_ID_INST[15:11];
  assign imm    = {{(DATA_W-16){IF_ID_INST[15]}}, IF_ID_INST[15:0]};
  reg_file #(.DATA_W(DATA_W), .ADDR_W(REG_ADDR_W)) u_rf (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .we_i      (WB_REG_WRITE),
    .waddr_i   (WB_WRITE_REG),
    .wdata_i   (WB_WRITE_DATA),
    .raddr_a_i (rs),
    .raddr_b_i (rt),
    .rdata_a_o (rs_data),
    .rdata_b_o (rt_data)
  );
  // A load in ID/EX whose target is read here must be held back one cycle
  assign hz = (LOAD_USE_STALL != 0) && IF_ID_VALID && valid_q && ctrl_q.mem_read && rt_q != '0 &&
              (rt_q == rs || (rt_q == rt && uses_rt(opcode)));
  assign STALL = hz && !FLUSH;
  assign ld    = IF_ID_VALID && !hz && !FLUSH;
  always_comb begin
    valid_d = ld;
    ctrl_d  = ld ? decode_ctrl(opcode) : CTRL_NOP;
    ill_d   = ld && !is_legal(opcode);
    npc_d   = ld ? IF_ID_NPC : '0;
    rsd_d   = ld ? rs_data : '0;
    rtd_d   = ld ? rt_data : '0;
    imm_d   = ld ? imm : '0;
    rs_d    = ld ? rs : '0;
    rt_d    = ld ? rt : '0;
    rd_d    = ld ? rd : '0;
  end
  always_ff @(posedge CLK or negedge RST_N)
    if (!RST_N) begin
      valid_q <= 1'b0;
      ctrl_q  <= CTRL_NOP;
      ill_q   <= 1'b0;
      npc_q   <= '0;
      rsd_q   <= '0;
      rtd_q   <= '0;
      imm_q   <= '0;
      rs_q    <= '0;
      rt_q    <= '0;
      rd_q    <= '0;
    end else begin
      valid_q <= valid_d;
      ctrl_q  <= ctrl_d;
      ill_q   <= ill_d;
      npc_q   <= npc_d;
      rsd_q   <= rsd_d;
      rtd_q   <= rtd_d;
      imm_q   <= imm_d;
      rs_q    <= rs_d;
      rt_q    <= rt_d;
      rd_q    <= rd_d;
    end
  assign ID_EX_VALID      = valid_q;
  assign ID_EX_NPC        = npc_q;
  assign ID_EX_RS_DATA    = rsd_q;
  assign ID_EX_RT_DATA    = rtd_q;
  assign ID_EX_IMM        = imm_q;
  assign ID_EX_RS         = rs_q;
  assign ID_EX_RT         = rt_q;
  assign ID_EX_RD         = rd_q;
  assign ID_EX_REG_DST    = ctrl_q.reg_dst;
  assign ID_EX_ALU_SRC    = ctrl_q.alu_src;
  assign ID_EX_MEM_READ   = ctrl_q.mem_read;
  assign ID_EX_MEM_WRITE  = ctrl_q.mem_write;
  assign ID_EX_MEM_TO_REG = ctrl_q.mem_to_reg;
  assign ID_EX_REG_WRITE  = ctrl_q.reg_write;
  assign ID_EX_BRANCH     = ctrl_q.branch;
  assign ID_EX_ALU_OP     = ctrl_q.alu_op;
  assign ILLEGAL          = ill_q;
endmodule

// File: doc/id_stage.md
Name: id_stage

Overview:
- Instruction-decode stage of the 5-stage MIPS pipeline. Sits directly downstream of the IF stage's IF/ID register and consumes its next-PC and instruction outputs.
- Decodes the instruction, reads the 32x32 register file (written from WB), and detects load-use hazards.
- Drives the ID/EX pipeline register that feeds EX.

Parameters:
- DATA_W, 32, datapath width (the ISA fixes it at 32).
- REG_ADDR_W, 5, register-index width.
- LOAD_USE_STALL, 1, 1 = hazard unit enabled; 0 = STALL tied to 0.

Ports:
- CLK  in  1  rising-edge clock; sole clock
- RST_N  in  1  asynchronous active-low reset
- IF_ID_NPC  in  32  PC+4 from IF/ID register
- IF_ID_INST  in  32  instruction from IF/ID register
- IF_ID_VALID  in  1  IF/ID holds a real instruction
- FLUSH  in  1  branch resolved taken; kill the instruction in ID
- WB_REG_WRITE  in  1  writeback enable
- WB_WRITE_REG  in  5  writeback register index
- WB_WRITE_DATA  in  32  writeback data
- STALL  out  1  hold PC and IF/ID this cycle (combinational)
- ID_EX_VALID  out  1  ID/EX holds a real instruction
- ID_EX_NPC  out  32  registered PC+4
- ID_EX_RS_DATA, ID_EX_RT_DATA  out  32 each  registered operands
- ID_EX_IMM  out  32  sign-extended imm16
- ID_EX_RS, ID_EX_RT, ID_EX_RD  out  5 each  register indices
- ID_EX_REG_DST, ID_EX_ALU_SRC, ID_EX_MEM_READ, ID_EX_MEM_WRITE, ID_EX_MEM_TO_REG, ID_EX_REG_WRITE, ID_EX_BRANCH  out  1 each  control bits
- ID_EX_ALU_OP  out  2  00 add, 01 sub, 10 funct-decoded
- ILLEGAL  out  1  registered; unsupported opcode was decoded

Behaviour:
- Reset (RST_N=0, async):
  - All ID_EX_* outputs, ID_EX_VALID and ILLEGAL are cleared to 0.
  - All 32 registers are cleared to 0.
  - STALL is 0 while in reset.
- Decode fields: opcode=[31:26], rs=[25:21], rt=[20:16], rd=[15:11], funct=[5:0], imm=sign-extend([15:0]).
- Control per opcode, in the order REG_DST, ALU_SRC, MEM_READ, MEM_WRITE, MEM_TO_REG, REG_WRITE, BRANCH, then ALU_OP:
  - 0x00 R-type: 1,0,0,0,0,1,0, ALU_OP=10
  - 0x23 lw: 0,1,1,0,1,1,0, ALU_OP=00
  - 0x2B sw: 0,1,0,1,0,0,0, ALU_OP=00
  - 0x04 beq: 0,0,0,0,0,0,1, ALU_OP=01
  - 0x08 addi: 0,1,0,0,0,1,0, ALU_OP=00
  - Any other opcode: all controls 0, and ILLEGAL=1 is registered alongside.
- Register file:
  - Written at the rising edge of CLK when WB_REG_WRITE=1 and WB_WRITE_REG!=0. Writes to $0 are dropped; $0 always reads 0.
  - Reads are combinational with write-through bypass: if WB_REG_WRITE=1, WB_WRITE_REG!=0 and the read index equals WB_WRITE_REG, the read returns WB_WRITE_DATA in the same cycle.
- Hazard: hz = LOAD_USE_STALL & IF_ID_VALID & ID_EX_VALID & ID_EX_MEM_READ & (ID_EX_RT!=0) & (ID_EX_RT==rs | (ID_EX_RT==rt & opcode uses rt)). Opcodes that use rt are R-type, sw and beq.
- STALL = hz & ~FLUSH.
- ID/EX update on each rising edge of CLK (no enable; the register always advances):
  - FLUSH=1: load a bubble (VALID=0, all controls 0, ILLEGAL=0). FLUSH has priority over the hazard.
  - Else if hz=1: load a bubble. The stalled instruction stays in IF/ID and is decoded again next cycle.
  - Else if IF_ID_VALID=0: load a bubble.
  - Else: load the decoded fields and controls, with VALID=1.
  - Data and index fields of a bubble are don't-care, but the RTL drives them to 0.
- Latency: one cycle from IF/ID to ID/EX. A load-use dependency inserts exactly one bubble.
- Simultaneous events:
  - A WB write and a decode of the same register in the same cycle: the bypass supplies the new value.
  - FLUSH asserted together with hz: STALL=0 and a bubble is loaded.
- Reset mid-operation: asserting RST_N immediately clears outputs and the register file. The first rising edge after deassertion decodes normally.

Decomposition:
- Package mips_pkg holds:
  - opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI);
  - ALU_OP encodings;
  - a packed ctrl_t struct of the seven control bits plus ALU_OP;
  - the bubble constant CTRL_NOP.
- One sub-module, reg_file: 32x32, two read ports with write-through bypass, one write port, $0 hardwired to zero, async active-low clear.
- Decode, hazard logic and the ID/EX register stay in id_stage.

Test Plan:
- Reset: assert RST_N=0 mid-run -> all ID_EX_* outputs and ILLEGAL=0 immediately; after release, reading $5 gives 0.
- Bypass: WB writes $8=0x1234_5678 while IF_ID_INST=add $9,$8,$0 (0x01004820) -> next edge ID_EX_RS_DATA=0x12345678, REG_DST=1, REG_WRITE=1, ALU_OP=10.
- Load-use: lw $2,4($1) (0x8C220004) then add $3,$2,$2 -> STALL=1 for exactly one cycle, one bubble (VALID=0), then the add issues with VALID=1.
- $0 protection: WB write $0=0xFFFF_FFFF, then decode addi $4,$0,-1 (0x2004FFFF) -> RS_DATA=0, IMM=0xFFFFFFFF, ALU_SRC=1.
- Flush priority: create the load-use condition with FLUSH=1 in the same cycle -> STALL=0 and a bubble is loaded.
- Illegal: opcode 0x3F -> ILLEGAL=1, all controls 0, VALID=1; next legal instruction clears ILLEGAL.
